// File: rtl/ram_read_scanner.sv
// Read-side scan sequencer for the display RAM: walks every address, holds each
// on the display for a fixed dwell, and keeps the shown word current by snooping writes.
module ram_read_scanner #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 3,
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic              step,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);

  localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    CAPTURE = 2'd1,
    DWELL   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              step_q;
  logic              snoop_flag;
  logic [DATA_W-1:0] snoop_data;

  logic snoop_win_c;
  logic capture_c;
  logic dwell_c;
  logic rd_match_c;
  logic disp_match_c;
  logic step_rise_c;
  logic expire_c;
  logic manual_c;
  logic advance_c;

  // State register
  always_ff @(posedge CLK) begin
    if (reset) state <= ISSUE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = DWELL;
      DWELL:   if (advance_c) state_nx = ISSUE;
      default: state_nx = ISSUE;
    endcase
  end

  // State decode and event qualification
  always_comb begin
    snoop_win_c = 1'b0;
    capture_c   = 1'b0;
    dwell_c     = 1'b0;
    case (state)
      ISSUE:   snoop_win_c = 1'b1;
      CAPTURE: begin
        snoop_win_c = 1'b1;
        capture_c   = 1'b1;
      end
      DWELL:   dwell_c = 1'b1;
      default: ;
    endcase
    rd_match_c   = wr_en && (wr_addr == rd_addr);
    disp_match_c = dwell_c && wr_en && (wr_addr == disp_addr);
    step_rise_c  = step && !step_q;
    expire_c     = dwell_c && enable && (cnt == CNT_LAST);
    manual_c     = dwell_c && !enable && step_rise_c;
    advance_c    = expire_c || manual_c;
  end

  // Datapath: address walk, dwell counter, snoop capture and display registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_addr    <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      cnt        <= '0;
      step_q     <= 1'b0;
      snoop_flag <= 1'b0;
      snoop_data <= '0;
    end else begin
      step_q     <= step;
      disp_valid <= 1'b0;

      if (snoop_win_c && rd_match_c) begin
        snoop_flag <= 1'b1;
        snoop_data <= wr_data;
      end

      // RAM returns old data on read-during-write, so a write in this cycle wins
      if (capture_c) begin
        snoop_flag <= 1'b0;
        disp_addr  <= rd_addr;
        disp_data  <= rd_match_c ? wr_data : (snoop_flag ? snoop_data : rd_data_in);
        disp_valid <= 1'b1;
        cnt        <= '0;
      end

      if (disp_match_c) begin
        disp_data  <= wr_data;
        disp_valid <= 1'b1;
      end

      if (dwell_c && enable) cnt <= cnt + CNT_W'(1);
      if (manual_c)          cnt <= '0;
      if (advance_c)         rd_addr <= rd_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_ram_read_scanner.sv
// Directed bench for ram_read_scanner with a small registered RAM model
// preloaded with mem[a] = a % 8 and a dwell of 4 cycles.
module tb_ram_read_scanner;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              step;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  logic [DATA_W-1:0] mem [32];

  int n_total = 0;
  int n_bad   = 0;
  int pulses;

  ram_read_scanner #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DWELL_CYCLES(4)
  ) dut (
    .CLK       (clk),
    .reset     (reset),
    .enable    (enable),
    .step      (step),
    .rd_addr   (rd_addr),
    .rd_data_in(rd_data_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = DATA_W'(i % 8);
  end

  // Registered RAM: read-during-write returns the old word
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_in <= mem[rd_addr];
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input int target);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (!found && n < 300) begin
      tick();
      n++;
      if (disp_valid && int'(disp_addr) == target) found = 1'b1;
    end
    check("reach_addr", int'(found), 1);
  endtask

  task automatic do_step(input int exp_addr);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    check("step_valid", int'(disp_valid), 1);
    check("step_addr", int'(disp_addr), exp_addr);
    check("step_data", int'(disp_data), exp_addr % 8);
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    step    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    tick();
    tick();
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_disp_addr", int'(disp_addr), 0);
    check("rst_disp_data", int'(disp_data), 0);
    check("rst_disp_valid", int'(disp_valid), 0);

    // Auto scan: first display on the 2nd edge, then one every 6 cycles, wrapping at 31
    reset = 1'b0;
    tick();
    check("first_edge_valid", int'(disp_valid), 0);
    tick();
    check("first_valid", int'(disp_valid), 1);
    check("first_addr", int'(disp_addr), 0);
    check("first_data", int'(disp_data), 0);
    for (int a = 1; a <= 32; a++) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        check("gap_valid", int'(disp_valid), 0);
        check("gap_addr", int'(disp_addr), (a - 1) % 32);
      end
      tick();
      check("scan_valid", int'(disp_valid), 1);
      check("scan_addr", int'(disp_addr), a % 32);
      check("scan_data", int'(disp_data), (a % 32) % 8);
    end

    // Pause at 5, then single step to 6; a held step does not repeat
    wait_addr(5);
    enable = 1'b0;
    pulses = 0;
    repeat (100) begin
      tick();
      if (disp_valid) pulses++;
    end
    check("pause_addr", int'(disp_addr), 5);
    check("pause_pulses", pulses, 0);
    step = 1'b1;
    tick();
    check("step_rd_addr", int'(rd_addr), 6);
    check("step_issue_valid", int'(disp_valid), 0);
    tick();
    check("step_capture_valid", int'(disp_valid), 0);
    tick();
    check("step6_valid", int'(disp_valid), 1);
    check("step6_addr", int'(disp_addr), 6);
    check("step6_data", int'(disp_data), 6);
    pulses = 0;
    repeat (20) begin
      tick();
      if (disp_valid) pulses++;
    end
    check("held_step_pulses", pulses, 0);
    check("held_step_addr", int'(disp_addr), 6);
    step = 1'b0;
    tick();
    do_step(7);
    do_step(8);

    // Write during CAPTURE of 9 overrides the stale RAM word
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 3'd6;
    tick();
    wr_en = 1'b0;
    check("cap_wr_addr", int'(disp_addr), 9);
    check("cap_wr_data", int'(disp_data), 6);

    // ISSUE write then CAPTURE write to 10: the later one wins
    step = 1'b1;
    tick();
    step = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 3'd7;
    tick();
    wr_data = 3'd3;
    tick();
    wr_en = 1'b0;
    check("two_wr_addr", int'(disp_addr), 10);
    check("two_wr_data", int'(disp_data), 3);

    // ISSUE-only write to 11: RAM still returns old 3, snoop supplies 5
    step = 1'b1;
    tick();
    step = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 3'd5;
    tick();
    wr_en = 1'b0;
    tick();
    check("issue_wr_addr", int'(disp_addr), 11);
    check("issue_wr_data", int'(disp_data), 5);

    // DWELL snoop on the displayed address; other addresses ignored
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 3'd1;
    tick();
    wr_en = 1'b0;
    check("dwell_wr_data", int'(disp_data), 1);
    check("dwell_wr_valid", int'(disp_valid), 1);
    tick();
    check("dwell_wr_valid_drop", int'(disp_valid), 0);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 3'd0;
    tick();
    wr_en = 1'b0;
    check("other_wr_data", int'(disp_data), 1);
    check("other_wr_valid", int'(disp_valid), 0);

    // Dwell expiry coinciding with a matching write: both take effect
    enable = 1'b1;
    tick();
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 3'd6;
    tick();
    wr_en = 1'b0;
    check("expire_wr_data", int'(disp_data), 6);
    check("expire_wr_valid", int'(disp_valid), 1);
    check("expire_wr_disp_addr", int'(disp_addr), 11);
    check("expire_rd_addr", int'(rd_addr), 12);
    tick();
    tick();
    check("after_expire_valid", int'(disp_valid), 1);
    check("after_expire_addr", int'(disp_addr), 12);
    check("after_expire_data", int'(disp_data), 0);

    // Reset mid-DWELL at 17 restarts the scan from 0
    wait_addr(17);
    check("addr17_data", int'(disp_data), 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_rd_addr", int'(rd_addr), 0);
    check("mid_rst_disp_addr", int'(disp_addr), 0);
    check("mid_rst_disp_data", int'(disp_data), 0);
    check("mid_rst_disp_valid", int'(disp_valid), 0);
    tick();
    check("restart_edge1_valid", int'(disp_valid), 0);
    tick();
    check("restart_valid", int'(disp_valid), 1);
    check("restart_addr", int'(disp_addr), 0);
    check("restart_data", int'(disp_data), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
